mem_access_ctrl: RTL and testbench

- Sequences every CPU load/store from the M stage onto the shared data-memory bus.
- Checks alignment, generates byte enables and replicated store data, and holds the bus request until the slave answers or a timeout expires.
- Sign/zero-extends load data and stalls the pipeline while an access is outstanding.
- Sits between the M-stage register and the data-memory/peripheral bus.

---
 rtl/mem_access_ctrl.sv | 156 +++++++++++++++
 tb/tb_mem_access_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Purpose: sequences M-stage loads/stores onto the data bus with alignment checks, lane steering and load extension.
// Latency: aligned access done on cycle 3 + wait cycles after the request cycle; misaligned access done on cycle 2.
// Backpressure: cpu_stall holds the pipeline while a request is pending; bus_req is held until ready, err or timeout.
module mem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [2:0]  cpu_op,
  output logic        cpu_stall,
  output logic        cpu_done,
  output logic [31:0] cpu_rdata,
  output logic        cpu_exc,
  output logic [4:0]  cpu_exc_code,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic        bus_err,
  input  logic [31:0] bus_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          lat_we;
  logic [1:0]    lat_off;
  logic [2:0]    lat_op;

  logic          req_byte;
  logic          req_half;
  logic          req_misaligned;
  logic [3:0]    req_be;
  logic [31:0]   req_wdata;
  logic [7:0]    lane8;
  logic [15:0]   lane16;
  logic [31:0]   load_ext;
  logic          timeout;
  logic [4:0]    dir_code;

  // Request decode: access width, alignment, byte enables and replicated store data.
  always_comb begin
    req_byte       = (cpu_op == 3'b001) || (cpu_op == 3'b010);
    req_half       = (cpu_op == 3'b011) || (cpu_op == 3'b100);
    req_misaligned = req_half ? cpu_addr[0] :
                     (!req_byte && (cpu_addr[1:0] != 2'b00));
    req_be         = 4'b1111;
    req_wdata      = cpu_wdata;
    if (req_byte) begin
      req_be    = 4'b0001 << cpu_addr[1:0];
      req_wdata = {4{cpu_wdata[7:0]}};
    end else if (req_half) begin
      req_be    = cpu_addr[1] ? 4'b1100 : 4'b0011;
      req_wdata = {2{cpu_wdata[15:0]}};
    end
  end

  // Load lane select and extension from the latched offset and op.
  always_comb begin
    case (lat_off)
      2'd0:    lane8 = bus_rdata[7:0];
      2'd1:    lane8 = bus_rdata[15:8];
      2'd2:    lane8 = bus_rdata[23:16];
      default: lane8 = bus_rdata[31:24];
    endcase
    lane16 = lat_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (lat_op)
      3'b001:  load_ext = {24'd0, lane8};
      3'b010:  load_ext = {{24{lane8[7]}}, lane8};
      3'b011:  load_ext = {16'd0, lane16};
      3'b100:  load_ext = {{16{lane16[15]}}, lane16};
      default: load_ext = bus_rdata;
    endcase
  end

  assign timeout   = (cnt == CW'(TIMEOUT_CYCLES - 1));
  assign dir_code  = lat_we ? 5'd5 : 5'd4;
  assign cpu_stall = (state == S_ACCESS) || ((state == S_IDLE) && cpu_req);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      lat_we       <= 1'b0;
      lat_off      <= 2'd0;
      lat_op       <= 3'd0;
      cpu_done     <= 1'b0;
      cpu_rdata    <= 32'd0;
      cpu_exc      <= 1'b0;
      cpu_exc_code <= 5'd0;
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= 32'd0;
      bus_be       <= 4'd0;
      bus_wdata    <= 32'd0;
    end else begin
      cpu_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cpu_req) begin
            if (req_misaligned) begin
              state        <= S_RESP;
              cpu_done     <= 1'b1;
              cpu_exc      <= 1'b1;
              cpu_exc_code <= cpu_we ? 5'd5 : 5'd4;
              cpu_rdata    <= 32'd0;
            end else begin
              state     <= S_ACCESS;
              cnt       <= '0;
              lat_we    <= cpu_we;
              lat_off   <= cpu_addr[1:0];
              lat_op    <= cpu_op;
              bus_req   <= 1'b1;
              bus_we    <= cpu_we;
              bus_addr  <= {cpu_addr[31:2], 2'b00};
              bus_be    <= req_be;
              bus_wdata <= req_wdata;
            end
          end
        end
        S_ACCESS: begin
          cnt <= cnt + CW'(1);
          // Error wins over a simultaneous ready; an expired wait is reported as an error.
          if (bus_err || (!bus_ready && timeout)) begin
            state        <= S_RESP;
            cpu_done     <= 1'b1;
            bus_req      <= 1'b0;
            cpu_exc      <= 1'b1;
            cpu_exc_code <= dir_code;
            cpu_rdata    <= 32'd0;
          end else if (bus_ready) begin
            state        <= S_RESP;
            cpu_done     <= 1'b1;
            bus_req      <= 1'b0;
            cpu_exc      <= 1'b0;
            cpu_exc_code <= 5'd0;
            cpu_rdata    <= lat_we ? 32'd0 : load_ext;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed plan cases plus randomized accesses vs. an arithmetic model.
module tb_mem_access_ctrl;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_addr = 32'd0;
  logic [31:0] cpu_wdata = 32'd0;
  logic [2:0]  cpu_op = 3'd0;
  logic        cpu_stall;
  logic        cpu_done;
  logic [31:0] cpu_rdata;
  logic        cpu_exc;
  logic [4:0]  cpu_exc_code;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ready = 1'b0;
  logic        bus_err = 1'b0;
  logic [31:0] bus_rdata = 32'd0;

  int n_vec = 0;
  int n_err = 0;
  int gcyc = 0;

  mem_access_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_op(cpu_op),
    .cpu_stall(cpu_stall), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_exc(cpu_exc),
    .cpu_exc_code(cpu_exc_code), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_err(bus_err),
    .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
    gcyc++;
  endtask

  // One CPU access starting in the current (IDLE) cycle, which is cycle 1.
  // mode: 0 ready after 'waits', 1 err, 2 err+ready together, 3 never answer (timeout).
  task automatic run_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [2:0] op, input int waits, input int mode,
                            input logic [31:0] rd, input string tag, output int first_breq);
    int sz, edone, ebreq, nbreq;
    logic mis, eexc, done;
    logic [3:0] ebe;
    logic [31:0] ewd, lane, erd;
    logic [4:0] ecode;
    sz = (op == 3'd1 || op == 3'd2) ? 1 : (op == 3'd3 || op == 3'd4) ? 2 : 4;
    mis = (int'(addr[1:0]) % sz) != 0;
    ebe = 4'((1 << sz) - 1) << addr[1:0];
    ewd = (sz == 1) ? {24'd0, wdata[7:0]} * 32'h01010101 :
          (sz == 2) ? {16'd0, wdata[15:0]} * 32'h00010001 : wdata;
    lane = rd >> (8 * addr[1:0]);
    if (sz < 4) begin
      lane = lane & ((32'd1 << (8 * sz)) - 32'd1);
      if ((op == 3'd2 || op == 3'd4) && lane >= (32'd1 << (8 * sz - 1)))
        lane = lane - (32'd1 << (8 * sz));
    end
    erd   = we ? 32'd0 : lane;
    eexc  = mis || (mode != 0);
    ecode = we ? 5'd5 : 5'd4;
    edone = mis ? 2 : (mode == 3) ? TO + 2 : 3 + waits;
    ebreq = mis ? 0 : (mode == 3) ? TO : waits + 1;

    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_op = op;
    nbreq = 0; done = 1'b0; first_breq = -1;
    for (int c = 1; c <= TO + 40 && !done; c++) begin
      bus_ready = 1'b0; bus_err = 1'b0; bus_rdata = $urandom;
      if (c == 1) begin
        bus_ready = 1'($urandom_range(0, 1));
        bus_err   = 1'($urandom_range(0, 1));
      end
      if (bus_req) begin
        if (first_breq < 0) first_breq = gcyc;
        n_vec++;
        if ({bus_we, bus_addr, bus_be} !== {we, addr[31:2], 2'b00, ebe}) begin
          n_err++;
          $display("FAIL %s bus_ctl: we/addr/be=%b/%h/%b want %b/%h/%b", tag, bus_we, bus_addr, bus_be,
                   we, {addr[31:2], 2'b00}, ebe);
        end
        if (we) begin
          n_vec++;
          if (bus_wdata !== ewd) begin
            n_err++;
            $display("FAIL %s bus_wdata: got %h want %h", tag, bus_wdata, ewd);
          end
        end
        if (nbreq == waits && mode != 3) begin
          bus_rdata = rd;
          bus_ready = (mode != 1);
          bus_err   = (mode != 0);
        end
        nbreq++;
      end
      #1;
      n_vec++;
      if (cpu_done) begin
        done = 1'b1;
        if ({c, nbreq, cpu_stall, cpu_exc} !== {edone, ebreq, 1'b0, eexc}) begin
          n_err++;
          $display("FAIL %s done: cycle/breq/stall/exc=%0d/%0d/%b/%b want %0d/%0d/0/%b", tag, c, nbreq,
                   cpu_stall, cpu_exc, edone, ebreq, eexc);
        end
        n_vec++;
        if (eexc && cpu_exc_code !== ecode) begin
          n_err++;
          $display("FAIL %s exc_code: got %0d want %0d", tag, cpu_exc_code, ecode);
        end else if (!eexc && cpu_rdata !== erd) begin
          n_err++;
          $display("FAIL %s rdata: got %h want %h", tag, cpu_rdata, erd);
        end
        cpu_req = 1'b0;
      end else if (cpu_stall !== 1'b1) begin
        n_err++;
        $display("FAIL %s stall: got %b want 1 in cycle %0d", tag, cpu_stall, c);
      end
      tick();
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL %s no_done: cpu_done missing, want it on cycle %0d", tag, edone);
    end
    cpu_req = 1'b0; bus_ready = 1'b0; bus_err = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({cpu_stall, cpu_done, cpu_rdata, cpu_exc, cpu_exc_code, bus_req, bus_we, bus_addr, bus_be,
         bus_wdata} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: req/done/stall=%b/%b/%b want all outputs 0", bus_req, cpu_done, cpu_stall);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_loads;
    int fb;
    run_access(1'b0, 32'h1003, 32'd0, 3'd2, 0, 0, 32'h80AA5511, "lb_signed", fb);
    run_access(1'b0, 32'h2002, 32'd0, 3'd3, 3, 0, 32'h9ABC1234, "lh_unsigned", fb);
    run_access(1'b0, 32'h2002, 32'd0, 3'd4, 3, 0, 32'h9ABC1234, "lh_signed", fb);
    run_access(1'b0, 32'h2000, 32'd0, 3'd7, 1, 0, 32'hCAFEF00D, "lw_op7", fb);
  endtask

  task automatic test_stores;
    int fb;
    run_access(1'b1, 32'h3001, 32'h000000EE, 3'd1, 2, 0, 32'd0, "sb", fb);
    run_access(1'b1, 32'h3002, 32'h000000EE, 3'd3, 1, 0, 32'd0, "sh", fb);
    run_access(1'b1, 32'h3004, 32'h12345678, 3'd0, 0, 0, 32'd0, "sw", fb);
  endtask

  task automatic test_misaligned;
    int fb;
    run_access(1'b0, 32'h4002, 32'd0, 3'd0, 0, 0, 32'd0, "mis_lw", fb);
    run_access(1'b1, 32'h4001, 32'd0, 3'd3, 0, 0, 32'd0, "mis_sh", fb);
  endtask

  task automatic test_errors;
    int fb;
    run_access(1'b0, 32'h5000, 32'd0, 3'd0, 0, 3, 32'd0, "timeout_ld", fb);
    run_access(1'b1, 32'h5004, 32'h1, 3'd0, 0, 3, 32'd0, "timeout_st", fb);
    run_access(1'b0, 32'h5008, 32'd0, 3'd0, 2, 2, 32'h11111111, "err_and_ready", fb);
    run_access(1'b1, 32'h500C, 32'h2, 3'd1, 1, 1, 32'd0, "err_store", fb);
  endtask

  task automatic test_reset_mid;
    int fb;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h6000; cpu_op = 3'd0;
    tick();
    tick();
    n_vec++;
    if (bus_req !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid_pre: bus_req=%b want 1 in 2nd ACCESS cycle", bus_req);
    end
    reset_n = 1'b0;
    cpu_req = 1'b0;
    #1;
    n_vec++;
    if ({bus_req, cpu_done} !== 2'b00) begin
      n_err++;
      $display("FAIL rst_mid_drop: bus_req/done=%b/%b want 0/0", bus_req, cpu_done);
    end
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (cpu_done !== 1'b0) begin
        n_err++;
        $display("FAIL rst_mid_nodone: cpu_done=%b want 0 after abandoned access", cpu_done);
      end
    end
    run_access(1'b0, 32'h6004, 32'd0, 3'd1, 1, 0, 32'h000000F0, "after_reset", fb);
  endtask

  task automatic test_back_to_back;
    int g0, fb1, fb2;
    g0 = gcyc;
    run_access(1'b0, 32'h7000, 32'd0, 3'd0, 0, 0, 32'h01020304, "b2b_ld", fb1);
    run_access(1'b1, 32'h7004, 32'hA5A5A5A5, 3'd0, 0, 0, 32'd0, "b2b_st", fb2);
    n_vec++;
    if (fb2 - g0 != 4) begin
      n_err++;
      $display("FAIL b2b_second_req: second bus_req on cycle %0d want cycle 5", fb2 - g0 + 1);
    end
  endtask

  task automatic test_random;
    int fb, waits, mode, r;
    logic [31:0] addr;
    for (int i = 0; i < 60; i++) begin
      addr = $urandom;
      if ($urandom_range(0, 1) == 0) addr[1:0] = 2'b00;
      waits = $urandom_range(0, 4);
      r = $urandom_range(0, 11);
      mode = (r < 8) ? 0 : (r < 10) ? 1 : (r < 11) ? 2 : 3;
      run_access(1'($urandom_range(0, 1)), addr, $urandom, 3'($urandom_range(0, 7)), waits, mode,
                 $urandom, "random", fb);
    end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_misaligned();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
